// File: rtl/i2c_cmd_arbiter_if.sv
// Requester / I2C-master handshake bundle for the codec control-path command arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface i2c_cmd_arbiter_if;
   logic        en_i;
   logic        req0_i;
   logic        req1_i;
   logic [15:0] data0_i;
   logic [15:0] data1_i;
   logic        ack0_o;
   logic        ack1_o;
   logic        err0_o;
   logic        err1_o;
   logic        i2c_start_o;
   logic [15:0] i2c_data_o;
   logic        i2c_busy_i;
   logic        i2c_done_i;
   logic        busy_o;
   logic        owner_o;

   modport slave (
      input  en_i, req0_i, req1_i, data0_i, data1_i, i2c_busy_i, i2c_done_i,
      output ack0_o, ack1_o, err0_o, err1_o, i2c_start_o, i2c_data_o, busy_o, owner_o
   );

   modport master (
      output en_i, req0_i, req1_i, data0_i, data1_i, i2c_busy_i, i2c_done_i,
      input  ack0_o, ack1_o, err0_o, err1_o, i2c_start_o, i2c_data_o, busy_o, owner_o
   );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C master between two 16-bit register-write requesters, with round-robin
// arbitration, NACK/timeout detection and bounded retries.
module i2c_cmd_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 1023,
   parameter int unsigned RETRY_MAX   = 2
) (
   input logic              clk_i2c,
   input logic              reg_rstn,
   i2c_cmd_arbiter_if.slave bus
);

   localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYC);
   localparam logic [1:0]  RetryMax   = 2'(RETRY_MAX);

   typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StResp} state_e;

   state_e      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [15:0] data_q, data_d;
   logic [1:0]  retry_q, retry_d;
   logic        fail_q, fail_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic        winner;
   logic        attempt_fail;

   always_ff @(posedge clk_i2c or negedge reg_rstn) begin
      if (!reg_rstn) begin
         state_q <= StIdle;
         timer_q <= '0;
         data_q  <= '0;
         retry_q <= '0;
         fail_q  <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         data_q  <= data_d;
         retry_q <= retry_d;
         fail_q  <= fail_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // On a tie, serve the port that did not own the previous transaction.
   assign winner = (bus.req0_i & bus.req1_i) ? ~last_q : bus.req1_i;

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      data_d       = data_q;
      retry_d      = retry_q;
      fail_d       = fail_q;
      owner_d      = owner_q;
      last_d       = last_q;
      attempt_fail = 1'b0;
      if (bus.en_i) begin
         unique case (state_q)
            StIdle: begin
               if ((bus.req0_i | bus.req1_i) & ~bus.i2c_busy_i) begin
                  state_d = StIssue;
                  owner_d = winner;
                  data_d  = winner ? bus.data1_i : bus.data0_i;
                  retry_d = '0;
                  fail_d  = 1'b0;
               end
            end
            StIssue: begin
               if (!bus.i2c_busy_i) begin
                  state_d = StWaitBusy;
                  timer_d = '0;
               end
            end
            StWaitBusy: begin
               if (bus.i2c_busy_i) begin
                  state_d = StWaitDone;
                  timer_d = '0;
               end else if (bus.i2c_done_i) begin
                  state_d = StResp;
               end else if (timer_q == TimeoutVal) begin
                  attempt_fail = 1'b1;
               end else begin
                  timer_d = timer_q + 16'd1;
               end
            end
            StWaitDone: begin
               if (bus.i2c_done_i) begin
                  state_d = StResp;
               end else if (!bus.i2c_busy_i || timer_q == TimeoutVal) begin
                  attempt_fail = 1'b1;
               end else begin
                  timer_d = timer_q + 16'd1;
               end
            end
            StResp: begin
               last_d  = owner_q;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase

         // retry_q counts up from zero, so inequality is the "retries left" test.
         if (attempt_fail) begin
            if (retry_q != RetryMax) begin
               retry_d = retry_q + 2'd1;
               state_d = StIssue;
            end else begin
               fail_d  = 1'b1;
               state_d = StResp;
            end
         end
      end
   end

   always_comb begin
      bus.ack0_o      = 1'b0;
      bus.ack1_o      = 1'b0;
      bus.err0_o      = 1'b0;
      bus.err1_o      = 1'b0;
      bus.i2c_start_o = (state_q == StIssue) & bus.en_i & ~bus.i2c_busy_i;
      bus.busy_o      = (state_q != StIdle);
      bus.i2c_data_o  = data_q;
      bus.owner_o     = owner_q;
      if (state_q == StResp) begin
         bus.ack0_o = ~owner_q;
         bus.ack1_o = owner_q;
         bus.err0_o = ~owner_q & fail_q;
         bus.err1_o = owner_q & fail_q;
      end
   end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Scoreboard bench for i2c_cmd_arbiter: a behavioural I2C master answers start pulses,
// expected completions are queued at request time and checked on each ack.
module tb_i2c_cmd_arbiter;

   logic clk_i2c = 1'b0;
   logic reg_rstn;
   always #5 clk_i2c = ~clk_i2c;

   i2c_cmd_arbiter_if bus ();
   i2c_cmd_arbiter_if bus_t ();

   i2c_cmd_arbiter u_dut (
      .clk_i2c  (clk_i2c),
      .reg_rstn (reg_rstn),
      .bus      (bus)
   );

   i2c_cmd_arbiter #(
      .TIMEOUT_CYC (8),
      .RETRY_MAX   (0)
   ) u_dut_tmo (
      .clk_i2c  (clk_i2c),
      .reg_rstn (reg_rstn),
      .bus      (bus_t)
   );

   typedef struct {
      bit          port;
      bit          err;
      logic [15:0] data;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   starts = 0;
   int   start_cyc = 0;
   int   acks_seen = 0;
   bit   drop0 = 1'b0;
   bit   drop1 = 1'b0;
   int   busy_len = 3;
   int   nack_n = 0;
   int   att = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk_i2c) cyc <= cyc + 1;

   // Monitor: count start pulses, pop and compare on every ack.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i2c);
         if (bus.i2c_start_o) begin
            starts++;
            start_cyc = cyc;
         end
         if (bus.ack0_o | bus.ack1_o) begin
            acks_seen++;
            check("ack_one_port", 32'(bus.ack0_o & bus.ack1_o), 0);
            check("sb_pending_at_ack", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("ack_port", 32'(bus.ack1_o), 32'(e.port));
               check("ack_err", 32'(bus.ack1_o ? bus.err1_o : bus.err0_o), 32'(e.err));
               check("ack_data", 32'(bus.i2c_data_o), 32'(e.data));
               check("ack_owner", 32'(bus.owner_o), 32'(e.port));
               if (e.lat >= 0) check("ack_latency", 32'(cyc - start_cyc), 32'(e.lat));
            end
            if (bus.ack1_o) drop1 = 1'b1;
            else            drop0 = 1'b1;
         end
      end
   end

   // Requesters drop req at the edge where ack is sampled.
   initial forever begin
      @(posedge clk_i2c);
      #1;
      if (drop0) begin bus.req0_i = 1'b0; drop0 = 1'b0; end
      if (drop1) begin bus.req1_i = 1'b0; drop1 = 1'b0; end
   end

   // I2C master model: busy the cycle after start for busy_len cycles, then done or NACK.
   initial begin
      bus.i2c_busy_i = 1'b0;
      bus.i2c_done_i = 1'b0;
      forever begin
         @(negedge clk_i2c);
         if (bus.i2c_start_o) begin
            att++;
            @(posedge clk_i2c);
            #1 bus.i2c_busy_i = 1'b1;
            repeat (busy_len - 1) begin
               @(posedge clk_i2c);
               #1;
            end
            @(posedge clk_i2c);
            #1;
            bus.i2c_busy_i = 1'b0;
            bus.i2c_done_i = (att > nack_n);
            @(posedge clk_i2c);
            #1 bus.i2c_done_i = 1'b0;
         end
      end
   end

   task automatic raise(input bit p, input logic [15:0] d, input bit err, input int lat);
      if (p) begin
         bus.data1_i = d;
         bus.req1_i  = 1'b1;
      end else begin
         bus.data0_i = d;
         bus.req0_i  = 1'b1;
      end
      sb_q.push_back('{p, err, d, lat});
   endtask

   task automatic wait_acks(input int n, input int budget);
      int target = acks_seen + n;
      for (int i = 0; i < budget && acks_seen < target; i++) @(posedge clk_i2c);
      check("ack_wait", 32'(acks_seen >= target), 1);
   endtask

   task automatic next_slot();
      @(posedge clk_i2c);
      #2;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int t_starts, t_start_cyc, t_ack_cyc, t_ack1;
      bit t_got, t_err;
      reg_rstn      = 1'b0;
      bus.en_i      = 1'b1;
      bus.req0_i    = 1'b0;
      bus.req1_i    = 1'b0;
      bus.data0_i   = '0;
      bus.data1_i   = '0;
      bus_t.en_i    = 1'b1;
      bus_t.req0_i  = 1'b0;
      bus_t.req1_i  = 1'b0;
      bus_t.data0_i = '0;
      bus_t.data1_i = '0;
      bus_t.i2c_busy_i = 1'b0;
      bus_t.i2c_done_i = 1'b0;

      // Both ports requesting from reset: port 0 first (last_owner resets to 1).
      raise(1'b0, 16'h0C10, 1'b0, 5);
      raise(1'b1, 16'h0579, 1'b0, 5);
      repeat (3) @(posedge clk_i2c);
      @(negedge clk_i2c);
      check("rst_busy", 32'(bus.busy_o), 0);
      check("rst_owner", 32'(bus.owner_o), 0);
      check("rst_data", 32'(bus.i2c_data_o), 0);
      check("rst_start", 32'(bus.i2c_start_o), 0);
      check("rst_acks", 32'({bus.ack0_o, bus.ack1_o, bus.err0_o, bus.err1_o}), 0);
      next_slot();
      reg_rstn = 1'b1;
      wait_acks(2, 100);
      check("pair1_starts", 32'(starts), 2);

      // Third simultaneous pair: port 1 was last, so port 0 first again.
      next_slot();
      raise(1'b0, 16'h0C11, 1'b0, 5);
      raise(1'b1, 16'h057A, 1'b0, 5);
      wait_acks(2, 100);

      // Port 0 alone; data change after grant must be ignored.
      s0 = starts;
      next_slot();
      raise(1'b0, 16'h1E00, 1'b0, 5);
      next_slot();
      bus.data0_i = 16'hFFFF;
      wait_acks(1, 100);
      check("single_starts", 32'(starts - s0), 1);

      // Port 0 was last, so a tie now goes to port 1.
      next_slot();
      raise(1'b1, 16'h0A5A, 1'b0, 5);
      raise(1'b0, 16'h1234, 1'b0, 5);
      wait_acks(2, 100);

      // NACK on every attempt: 1 + RETRY_MAX starts, then error.
      busy_len = 2; nack_n = 3; att = 0; s0 = starts;
      next_slot();
      raise(1'b0, 16'h0123, 1'b1, -1);
      wait_acks(1, 200);
      check("nack_all_starts", 32'(starts - s0), 3);

      // NACK once, then success.
      nack_n = 1; att = 0; s0 = starts;
      next_slot();
      raise(1'b1, 16'h0456, 1'b0, -1);
      wait_acks(1, 200);
      check("nack_once_starts", 32'(starts - s0), 2);

      // Fastest master: start to ack in 3 cycles.
      busy_len = 1; nack_n = 0; att = 0;
      next_slot();
      raise(1'b0, 16'h0789, 1'b0, 3);
      wait_acks(1, 100);

      // en_i low in ISSUE holds off start; exactly one start once re-enabled.
      s0 = starts;
      next_slot();
      raise(1'b1, 16'h0ABC, 1'b0, 3);
      next_slot();
      bus.en_i = 1'b0;
      repeat (3) @(posedge clk_i2c);
      check("en_hold_start", 32'(starts - s0), 0);
      #2 bus.en_i = 1'b1;
      wait_acks(1, 100);
      check("en_starts", 32'(starts - s0), 1);

      // Reset in WAIT_DONE: no ack, outputs to reset values, then a clean re-request.
      busy_len = 6;
      next_slot();
      raise(1'b1, 16'h0579, 1'b0, -1);
      repeat (4) @(posedge clk_i2c);
      #2;
      check("pre_rst_busy", 32'(bus.busy_o), 1);
      reg_rstn   = 1'b0;
      bus.req1_i = 1'b0;
      sb_q.delete();
      @(negedge clk_i2c);
      check("mid_rst_busy", 32'(bus.busy_o), 0);
      check("mid_rst_owner", 32'(bus.owner_o), 0);
      check("mid_rst_data", 32'(bus.i2c_data_o), 0);
      check("mid_rst_ack", 32'({bus.ack0_o, bus.ack1_o, bus.i2c_start_o}), 0);
      next_slot();
      reg_rstn = 1'b1;
      for (int i = 0; i < 50 && (bus.i2c_busy_i || bus.i2c_done_i); i++) @(posedge clk_i2c);
      check("master_idle", 32'(bus.i2c_busy_i), 0);
      next_slot();
      raise(1'b1, 16'h0579, 1'b0, 8);
      wait_acks(1, 100);

      // Timeout instance (TIMEOUT_CYC=8, RETRY_MAX=0): ack 1 + (8+1) cycles after start.
      t_starts = 0; t_start_cyc = 0; t_ack_cyc = 0; t_ack1 = 0; t_got = 1'b0; t_err = 1'b0;
      next_slot();
      bus_t.data0_i = 16'h1234;
      bus_t.req0_i  = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_i2c);
         if (bus_t.i2c_start_o) begin
            t_starts++;
            t_start_cyc = cyc;
         end
         if (bus_t.ack1_o) t_ack1++;
         if (bus_t.ack0_o && !t_got) begin
            t_got     = 1'b1;
            t_ack_cyc = cyc;
            t_err     = bus_t.err0_o;
            @(posedge clk_i2c);
            #1 bus_t.req0_i = 1'b0;
         end
      end
      check("tmo_ack_seen", 32'(t_got), 1);
      check("tmo_latency", 32'(t_ack_cyc - t_start_cyc), 32'(1 + 8 + 1));
      check("tmo_err", 32'(t_err), 1);
      check("tmo_starts", 32'(t_starts), 1);
      check("tmo_no_ack1", 32'(t_ack1), 0);
      check("tmo_data", 32'(bus_t.i2c_data_o), 32'h1234);

      repeat (5) @(posedge clk_i2c);
      check("sb_empty", 32'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_cmd_arbiter.md
# i2c_cmd_arbiter

Shares the single I2C master between two 16-bit register-write requesters on the codec control path: port 0 (power-up configuration sequencer) and port 1 (runtime volume/mute control).

- Accepts one request at a time, latches its data word, pulses the I2C master start and tracks busy/done.
- Detects no-acknowledge and timeout, retries a bounded number of times, then reports completion or error to the owning requester.

## Interface
- TIMEOUT_CYC, 1023: cycles allowed in WAIT_BUSY or WAIT_DONE before the attempt fails; legal 1..65535.
- RETRY_MAX, 2: re-issues after a failed attempt; legal 0..3.

- clk_i2c  in  1  I2C-domain clock.
- reg_rstn  in  1  Reset, asynchronous, active-low.
- en_i  in  1  State-advance enable; low freezes the FSM, timer and retry counter.
- req0_i / req1_i  in  1  Request level; held until the matching ack.
- data0_i / data1_i  in  16  Register word {addr[6:0], data[8:0]}; sampled at grant only.
- ack0_o / ack1_o  out  1  One-cycle completion pulse to the owning port.
- err0_o / err1_o  out  1  Coincident with ack; high if all attempts failed.
- i2c_start_o  out  1  One-cycle start pulse to the I2C master.
- i2c_data_o  out  16  Latched word; stable from grant to RESP.
- i2c_busy_i  in  1  I2C master transfer in progress.
- i2c_done_i  in  1  I2C master ACKed-completion pulse.
- busy_o  out  1  High in every state except IDLE.
- owner_o  out  1  Current or last granted port.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP. All transitions occur only when en_i=1.
- IDLE: if (req0_i|req1_i) & ~i2c_busy_i, grant and go to ISSUE.
  - Single requester wins.
  - Both requesting: winner is the port != last_owner (round robin).
  - On grant: latch data to i2c_data_o, set owner_o, clear retry_cnt, clear fail flag.
- ISSUE: i2c_start_o=1 only if ~i2c_busy_i; then go to WAIT_BUSY with timer=0. If busy, wait in ISSUE with start low.
- WAIT_BUSY:
  - i2c_busy_i=1 → WAIT_DONE, timer=0.
  - i2c_done_i=1 → RESP, success (fast master).
  - timer==TIMEOUT_CYC → failure.
  - Otherwise timer+1.
- WAIT_DONE:
  - i2c_done_i=1 → RESP, success (done takes priority over busy falling in the same cycle).
  - ~i2c_busy_i without done → failure (NACK).
  - timer==TIMEOUT_CYC → failure.
  - Otherwise timer+1.
- Failure: if retry_cnt<RETRY_MAX, increment retry_cnt and go to ISSUE (same data). Else set fail flag and go to RESP.
- RESP: ackN_o=1 for owner N; errN_o=fail flag; last_owner<=owner; → IDLE.
- Requester contract:
  - Drops req at the edge where it samples ack.
  - A new request needs a new data word valid on or before the grant edge.
  - data_i changes after grant are ignored.
- Widths: timer is 16 bits, saturating at TIMEOUT_CYC; retry_cnt is 2 bits.

## Timing
- Reset values:
  - State IDLE; all pulses, busy_o and err outputs 0.
  - i2c_data_o=16'h0000; owner_o=0; last_owner=1, so port 0 wins the first tie.
  - timer=0, retry_cnt=0.
- Grant edge to i2c_start_o: 1 cycle.
- Minimum grant-to-ack: 3 cycles (busy rises in the cycle after start, done one cycle later; RESP is the 4th state).
- ack/err are Moore outputs of RESP, exactly 1 cycle wide, never both ports at once.
- en_i low during ISSUE: start is held off; no duplicate start is issued when en_i returns.
- Reset mid-transaction: immediate return to IDLE with no ack. The requester must re-request.
- Back-to-back: IDLE is at least 1 cycle between transactions, so after RESP both ports are re-arbitrated.

## Test plan
- Port 0 only, data0=16'h1E00, master busy 3 cycles then done → one start pulse, i2c_data_o=16'h1E00, ack0 pulse, err0=0, ack1 never high.
- req0 and req1 both high from reset (data 16'h0C10 / 16'h0579), master always ACKs → port 0 served first, then port 1; a third simultaneous pair is served port 0 next (round robin).
- NACK: busy rises then falls without done on every attempt, RETRY_MAX=2 → exactly 3 start pulses, then ack0=1 with err0=1.
- NACK on first attempt, done on second → 2 start pulses, ack=1, err=0.
- Timeout: TIMEOUT_CYC=8, busy never rises, RETRY_MAX=0 → ack with err=1 at 9 cycles after ISSUE (WAIT_BUSY runs timer 0..8); no further start.
- Reset asserted in WAIT_DONE → all outputs reset values next cycle. Re-request after release → normal completion.
